// File: rtl/capsense_scanner.sv
// Capacitive-touch scan controller: discharge/charge/measure per pad, baseline calibration, debounced flags.
// Latency: count_o one cycle after STORE; buttons_o/calibrated_o update on the edge frame_done_o rises.
// Backpressure: none; count_vld_o and frame_done_o are unacknowledged one-cycle pulses.
module capsense_scanner #(
    parameter int N       = 4,
    parameter int CNT_W   = 12,
    parameter int DIS_CYC = 16,
    parameter int MAX_CNT = 4095,
    parameter int THRESH  = 8,
    parameter int DEB     = 3,
    localparam int CH_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             scan_en_i,
    input  logic             recal_i,
    input  logic [N-1:0]     pad_i,
    output logic [N-1:0]     pad_oe_o,
    output logic [N-1:0]     buttons_o,
    output logic             calibrated_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CH_W-1:0]  count_ch_o,
    output logic             count_vld_o
);

    localparam int               DIS_W    = $clog2(DIS_CYC + 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N - 1);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CNT);
    localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DIS_CYC - 1);
    localparam logic [3:0]       DEB_LAST = 4'(DEB - 1);
    localparam logic [CNT_W:0]   THRESH_W = (CNT_W + 1)'(THRESH);

    typedef enum logic [1:0] {IDLE, DISCHARGE, CHARGE, STORE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pad_meta, pad_sync;
    logic [CH_W-1:0]  ch;
    logic [DIS_W-1:0] dis_cnt;
    logic [CNT_W-1:0] cnt;
    logic             cal_pending, cal_frame;
    logic [CNT_W-1:0] baseline [N];
    logic [3:0]       deb [N];
    logic [N-1:0]     raw_q, raw_d;
    logic             frame_start, frame_end;
    logic             timeout, over_thresh;
    logic [CNT_W:0]   limit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_meta <= '0;
            pad_sync <= '0;
        end else begin
            pad_meta <= pad_i;
            pad_sync <= pad_meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_en_i) begin
                    state_d     = DISCHARGE;
                    frame_start = 1'b1;
                end
            end
            DISCHARGE: begin
                if (dis_cnt == DIS_LAST) state_d = CHARGE;
            end
            CHARGE: begin
                if (pad_sync[ch] || timeout) state_d = STORE;
            end
            STORE: begin
                if (ch == LAST_CH) begin
                    frame_end = 1'b1;
                    if (scan_en_i) begin
                        state_d     = DISCHARGE;
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DISCHARGE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pads are only released while charging; every other state keeps them discharged.
    assign pad_oe_o = (state_q == CHARGE) ? '0 : '1;

    // Threshold sum carries an extra bit so a high baseline cannot wrap.
    assign timeout     = (cnt == MAX_C);
    assign limit       = {1'b0, baseline[ch]} + THRESH_W;
    assign over_thresh = ({1'b0, cnt} > limit);

    always_comb begin
        raw_d = raw_q;
        if (state_q == STORE && !cal_frame) raw_d[ch] = over_thresh || timeout;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch           <= '0;
            dis_cnt      <= '0;
            cnt          <= '0;
            cal_pending  <= 1'b1;
            cal_frame    <= 1'b0;
            raw_q        <= '0;
            buttons_o    <= '0;
            calibrated_o <= 1'b0;
            frame_done_o <= 1'b0;
            count_o      <= '0;
            count_ch_o   <= '0;
            count_vld_o  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                baseline[i] <= '0;
                deb[i]      <= '0;
            end
        end else begin
            raw_q        <= raw_d;
            frame_done_o <= frame_end;
            count_vld_o  <= (state_q == STORE);

            if (state_q == DISCHARGE) dis_cnt <= dis_cnt + DIS_W'(1);
            else                      dis_cnt <= '0;

            if (state_q == CHARGE) begin
                if (state_d == CHARGE) cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end

            // A recal in the frame-start cycle lands in cal_pending for the following frame.
            if (frame_start) begin
                cal_frame   <= cal_pending;
                cal_pending <= recal_i;
            end else if (recal_i) begin
                cal_pending <= 1'b1;
            end

            if (frame_start)                            ch <= '0;
            else if (state_q == STORE && ch != LAST_CH) ch <= ch + CH_W'(1);

            if (state_q == STORE) begin
                count_o    <= cnt;
                count_ch_o <= ch;
                if (cal_frame) baseline[ch] <= cnt;
            end

            if (frame_end) begin
                if (cal_frame) calibrated_o <= 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (cal_frame) begin
                        buttons_o[i] <= 1'b0;
                        deb[i]       <= '0;
                    end else if (raw_d[i] != buttons_o[i]) begin
                        if (deb[i] == DEB_LAST) begin
                            buttons_o[i] <= raw_d[i];
                            deb[i]       <= '0;
                        end else begin
                            deb[i] <= deb[i] + 4'd1;
                        end
                    end else begin
                        deb[i] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_capsense_scanner.sv
// Directed bench for capsense_scanner: a behavioural pad model rises a set number of cycles after release.
module tb_capsense_scanner;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        scan_en_i;
    logic        recal_i;
    logic [3:0]  pad_i;
    logic [3:0]  pad_oe_o;
    logic [3:0]  buttons_o;
    logic        calibrated_o;
    logic        frame_done_o;
    logic [11:0] count_o;
    logic [1:0]  count_ch_o;
    logic        count_vld_o;

    capsense_scanner dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .scan_en_i    (scan_en_i),
        .recal_i      (recal_i),
        .pad_i        (pad_i),
        .pad_oe_o     (pad_oe_o),
        .buttons_o    (buttons_o),
        .calibrated_o (calibrated_o),
        .frame_done_o (frame_done_o),
        .count_o      (count_o),
        .count_ch_o   (count_ch_o),
        .count_vld_o  (count_vld_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [15:0] NEVER = 16'hFFFF;

    typedef struct packed {
        logic [15:0] d0, d1, d2, d3;
        logic [11:0] c0, c1, c2, c3;
        logic [3:0]  btn;
        logic        recal;
    } vec_t;

    int   dly [4];
    int   since;
    int   got_cnt [4];
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs [22];

    // Pad p reads 1 once dly[p] cycles have passed since the pads were released.
    initial begin
        since = -1;
        pad_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (pad_oe_o[0]) begin
                since = -1;
                pad_i = '0;
            end else begin
                since++;
                for (int p = 0; p < 4; p++) pad_i[p] = (since >= dly[p]);
            end
        end
    end

    always @(negedge clk_i) if (count_vld_o) got_cnt[count_ch_o] = int'(count_o);

    function automatic vec_t mk(input logic [15:0] d0, d1, d2, d3,
                                input logic [11:0] c0, c1, c2, c3,
                                input logic [3:0] btn, input logic recal);
        vec_t v;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
        v.btn = btn; v.recal = recal;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk_i);
            if (frame_done_o) begin
                ok = 1'b1;
                break;
            end
        end
        #2;
    endtask

    task automatic set_dly(input int a, b, c, d);
        dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
    endtask

    initial begin
        bit ok;
        bit idle_ok;

        // Baseline 12 on every pad after the first frame, threshold 8: counts above 20 read as touched.
        vecs[0]  = mk(10, 10, 10, 10,   12, 12, 12, 12,   4'b0000, 0);
        vecs[1]  = mk(10, 10, 30, 10,   12, 12, 32, 12,   4'b0000, 0);
        vecs[2]  = mk(10, 10, 30, 10,   12, 12, 32, 12,   4'b0000, 0);
        vecs[3]  = mk(10, 10, 30, 10,   12, 12, 32, 12,   4'b0100, 0);
        vecs[4]  = mk(30, 10, 30, 10,   32, 12, 32, 12,   4'b0100, 0);
        vecs[5]  = mk(30, 10, 30, 10,   32, 12, 32, 12,   4'b0100, 0);
        vecs[6]  = mk(10, 10, 30, 10,   12, 12, 32, 12,   4'b0100, 0);
        vecs[7]  = mk(10, NEVER, 30, 10, 12, 4095, 32, 12, 4'b0100, 0);
        vecs[8]  = mk(10, NEVER, 30, 10, 12, 4095, 32, 12, 4'b0100, 0);
        vecs[9]  = mk(10, NEVER, 30, 10, 12, 4095, 32, 12, 4'b0110, 0);
        vecs[10] = mk(10, 10, 10, 10,   12, 12, 12, 12,   4'b0110, 0);
        vecs[11] = mk(10, 10, 30, 10,   12, 12, 32, 12,   4'b0110, 0);
        vecs[12] = mk(10, 10, 10, 10,   12, 12, 12, 12,   4'b0100, 0);
        vecs[13] = mk(10, 10, 30, 10,   12, 12, 32, 12,   4'b0100, 0);
        vecs[14] = mk(30, 10, 10, 10,   32, 12, 12, 12,   4'b0100, 0);
        vecs[15] = mk(30, 10, 10, 10,   32, 12, 12, 12,   4'b0100, 0);
        vecs[16] = mk(30, 10, 10, 10,   32, 12, 12, 12,   4'b0001, 0);
        vecs[17] = mk(30, 10, 10, 23,   32, 12, 12, 25,   4'b0001, 1);
        vecs[18] = mk(30, 10, 10, 23,   32, 12, 12, 25,   4'b0000, 0);
        vecs[19] = mk(30, 10, 10, 23,   32, 12, 12, 25,   4'b0000, 0);
        vecs[20] = mk(30, 10, 10, 23,   32, 12, 12, 25,   4'b0000, 0);
        vecs[21] = mk(30, 10, 10, 23,   32, 12, 12, 25,   4'b0000, 0);

        rst_ni    = 1'b0;
        scan_en_i = 1'b0;
        recal_i   = 1'b0;
        set_dly(10, 10, 10, 10);
        for (int i = 0; i < 4; i++) got_cnt[i] = 0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);

        chk("reset_pad_oe",       pad_oe_o, 4'hF);
        chk("reset_buttons",      buttons_o, 0);
        chk("reset_calibrated",   calibrated_o, 0);
        chk("reset_frame_done",   frame_done_o, 0);
        chk("reset_count",        count_o, 0);
        chk("reset_count_ch",     count_ch_o, 0);
        chk("reset_count_vld",    count_vld_o, 0);

        scan_en_i = 1'b1;
        for (int i = 0; i < 22; i++) begin
            set_dly(int'(vecs[i].d0), int'(vecs[i].d1), int'(vecs[i].d2), int'(vecs[i].d3));
            if (vecs[i].recal) begin
                repeat (40) @(negedge clk_i);
                recal_i = 1'b1;
                @(negedge clk_i);
                recal_i = 1'b0;
            end
            wait_frame(ok);
            chk($sformatf("v%0d_frame_seen", i), ok, 1);
            chk($sformatf("v%0d_count_ch0", i), got_cnt[0], int'(vecs[i].c0));
            chk($sformatf("v%0d_count_ch1", i), got_cnt[1], int'(vecs[i].c1));
            chk($sformatf("v%0d_count_ch2", i), got_cnt[2], int'(vecs[i].c2));
            chk($sformatf("v%0d_count_ch3", i), got_cnt[3], int'(vecs[i].c3));
            chk($sformatf("v%0d_buttons", i), buttons_o, int'(vecs[i].btn));
            chk($sformatf("v%0d_calibrated", i), calibrated_o, 1);
            for (int c = 0; c < 4; c++) got_cnt[c] = 0;
        end

        // Drop scan enable after ch0 of the next frame: the frame must still finish through ch3.
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (count_vld_o && count_ch_o == 2'd0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stop_ch0_seen", ok, 1);
        scan_en_i = 1'b0;
        wait_frame(ok);
        chk("stop_frame_done", ok, 1);
        chk("stop_last_ch", count_ch_o, 3);
        chk("stop_ch3_count", got_cnt[3], 25);
        idle_ok = 1'b1;
        repeat (60) begin
            @(negedge clk_i);
            if (pad_oe_o != 4'hF || count_vld_o || frame_done_o) idle_ok = 1'b0;
        end
        chk("stop_idle_quiet", idle_ok, 1);

        // Reset in the middle of a charge phase releases nothing and restarts with calibration.
        scan_en_i = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (pad_oe_o == 4'h0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_charge_reached", ok, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_pad_oe", pad_oe_o, 4'hF);
        chk("rst_async_calibrated", calibrated_o, 0);
        chk("rst_async_buttons", buttons_o, 0);
        chk("rst_async_count", count_o, 0);
        @(negedge clk_i);
        set_dly(10, 10, 10, 23);
        for (int c = 0; c < 4; c++) got_cnt[c] = 0;
        rst_ni = 1'b1;
        wait_frame(ok);
        chk("recal_frame_done", ok, 1);
        chk("recal_calibrated", calibrated_o, 1);
        chk("recal_buttons", buttons_o, 0);
        chk("recal_count_ch0", got_cnt[0], 12);
        chk("recal_count_ch3", got_cnt[3], 25);
        @(negedge clk_i);
        chk("frame_done_one_cycle", frame_done_o, 0);
        scan_en_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
